hld_mem_channel_arbiter: RTL and testbench

Parametrised N-read/M-write arbiter that multiplexes accelerator memory channels onto one SPL/CCI read channel and one write channel, all on the fast clock `clk`. It stamps the port id into the request tag and routes each response back by that tag. It adds three things the fixed 2x2 mux lacks:
- per-port outstanding-request limits;
- real response back-pressure;
- a quiescence (idle) output that replaces ad-hoc done-delay counters.

---
 rtl/hld_mem_arb_pkg.sv | 37 +++
 rtl/hld_mem_channel_arbiter_rr.sv | 47 ++++
 rtl/hld_mem_channel_arbiter.sv | 222 ++++++++++++++++++++++
 tb/tb_hld_mem_channel_arbiter.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hld_mem_arb_pkg.sv
// Shared defaults and tag helpers for the memory channel arbiter.
// Port ids live in the top bits of every request/response tag.
package hld_mem_arb_pkg;

  localparam int DEF_RD_REQ_W       = 80;
  localparam int DEF_RD_RESP_W      = 528;
  localparam int DEF_WR_REQ_W       = 606;
  localparam int DEF_WR_RESP_W      = 17;
  localparam int DEF_TAG_W          = 16;
  localparam int DEF_WR_REQ_TAG_LSB = 576;
  localparam int DEF_WR_RESP_TAG_LSB = 0;
  localparam int MAX_BUS_W          = 1024;

  function automatic int calcPidW(input int rdPorts, input int wrPorts);
    int maxPorts;
    int w;
    maxPorts = (rdPorts > wrPorts) ? rdPorts : wrPorts;
    w = $clog2(maxPorts);
    return (w < 1) ? 1 : w;
  endfunction

  // Replaces the pidW bits just below and including tagMsb with pid (pid = 0 clears them).
  function automatic logic [MAX_BUS_W-1:0] setTagPid(
    input logic [MAX_BUS_W-1:0] bus,
    input int                   tagMsb,
    input int                   pidW,
    input logic [15:0]          pid
  );
    logic [MAX_BUS_W-1:0] res;
    res = bus;
    for (int i = 0; i < 16; i++) begin
      if (i < pidW) res[10'(tagMsb - i)] = pid[4'(pidW - 1 - i)];
    end
    return res;
  endfunction

endpackage

// File: rtl/hld_mem_channel_arbiter_rr.sv
// Round-robin arbiter: one-hot grant among eligible requesters, search starts after
// the last granted port and the pointer follows each grant.
module hld_rr_arbiter
  import hld_mem_arb_pkg::*;
#(
  parameter int N = 2,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N-1:0]     eligible,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grantIdx
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] cand;
  logic             found;
  int               candInt;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    found    = 1'b0;
    candInt  = 0;
    cand     = '0;
    for (int off = 1; off <= N; off++) begin
      candInt = (int'(ptr_q) + off) % N;
      cand    = IDX_W'(candInt);
      if (en && !found && eligible[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grantIdx    = cand;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= grantIdx;
    end
  end

endmodule

// File: rtl/hld_mem_channel_arbiter.sv
// Merges N read / M write accelerator channels onto single SPL read/write channels,
// stamping the port id into each tag and routing responses back by that id.
module hld_mem_channel_arbiter
  import hld_mem_arb_pkg::*;
#(
  parameter int RD_PORTS        = 2,
  parameter int WR_PORTS        = 2,
  parameter int RD_REQ_W        = DEF_RD_REQ_W,
  parameter int RD_RESP_W       = DEF_RD_RESP_W,
  parameter int WR_REQ_W        = DEF_WR_REQ_W,
  parameter int WR_REQ_TAG_LSB  = DEF_WR_REQ_TAG_LSB,
  parameter int WR_RESP_W       = DEF_WR_RESP_W,
  parameter int TAG_W           = DEF_TAG_W,
  parameter int MAX_OUTSTANDING = 64,
  parameter int IDLE_CYCLES     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RD_PORTS-1:0]          rd_req_in_valid,
  input  logic [RD_PORTS*RD_REQ_W-1:0] rd_req_in_data,
  output logic [RD_PORTS-1:0]          rd_req_in_ready,
  output logic                         rd_req_out_valid,
  input  logic                         rd_req_out_ready,
  output logic [RD_REQ_W-1:0]          rd_req_out_data,
  input  logic                         rd_resp_in_valid,
  output logic                         rd_resp_in_ready,
  input  logic [RD_RESP_W-1:0]         rd_resp_in_data,
  output logic [RD_PORTS-1:0]          rd_resp_out_valid,
  input  logic [RD_PORTS-1:0]          rd_resp_out_ready,
  output logic [RD_RESP_W-1:0]         rd_resp_out_data,
  input  logic [WR_PORTS-1:0]          wr_req_in_valid,
  output logic [WR_PORTS-1:0]          wr_req_in_ready,
  input  logic [WR_PORTS*WR_REQ_W-1:0] wr_req_in_data,
  output logic                         wr_req_out_valid,
  input  logic                         wr_req_out_ready,
  output logic [WR_REQ_W-1:0]          wr_req_out_data,
  input  logic                         wr_resp_in_valid,
  output logic                         wr_resp_in_ready,
  input  logic [WR_RESP_W-1:0]         wr_resp_in_data,
  output logic [WR_PORTS-1:0]          wr_resp_out_valid,
  input  logic [WR_PORTS-1:0]          wr_resp_out_ready,
  output logic [WR_RESP_W-1:0]         wr_resp_out_data,
  output logic                         idle,
  output logic [1:0]                   err
);

  localparam int PID_W          = calcPidW(RD_PORTS, WR_PORTS);
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING) + 1;
  localparam int IDLE_W         = $clog2(IDLE_CYCLES + 1);
  localparam int RD_IDX_W       = (RD_PORTS > 1) ? $clog2(RD_PORTS) : 1;
  localparam int WR_IDX_W       = (WR_PORTS > 1) ? $clog2(WR_PORTS) : 1;
  localparam int WR_REQ_TAG_MSB = WR_REQ_TAG_LSB + TAG_W - 1;

  logic [RD_PORTS-1:0] rdEligible, rdGrant, rdDec, rdZero;
  logic [WR_PORTS-1:0] wrEligible, wrGrant, wrDec, wrZero;
  logic [RD_IDX_W-1:0] rdGrantIdx;
  logic [WR_IDX_W-1:0] wrGrantIdx;
  logic [RD_REQ_W-1:0] rdSel, rdTagged;
  logic [WR_REQ_W-1:0] wrSel, wrTagged;
  logic                rdCanLoad, wrCanLoad;
  logic [PID_W-1:0]    rdRespPid, wrRespPid;
  logic                rdRespPidOk, wrRespPidOk;
  logic                rdUnderflow, wrUnderflow, badPid, quiet;

  logic                rdOutValid_q, wrOutValid_q;
  logic [RD_REQ_W-1:0] rdOutData_q;
  logic [WR_REQ_W-1:0] wrOutData_q;
  logic [CNT_W-1:0]    rdCnt_q [RD_PORTS];
  logic [CNT_W-1:0]    wrCnt_q [WR_PORTS];
  logic [IDLE_W-1:0]   idleCnt_q;
  logic [1:0]          err_q;

  // A new request may load whenever the holding register is empty or draining.
  assign rdCanLoad = !rdOutValid_q || rd_req_out_ready;
  assign wrCanLoad = !wrOutValid_q || wr_req_out_ready;

  always_comb begin
    rdEligible = '0;
    rdZero     = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      rdEligible[p] = rd_req_in_valid[p] && (rdCnt_q[p] < CNT_W'(MAX_OUTSTANDING));
      rdZero[p]     = (rdCnt_q[p] == '0);
    end
    wrEligible = '0;
    wrZero     = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      wrEligible[p] = wr_req_in_valid[p] && (wrCnt_q[p] < CNT_W'(MAX_OUTSTANDING));
      wrZero[p]     = (wrCnt_q[p] == '0);
    end
  end

  hld_rr_arbiter #(.N(RD_PORTS)) u_rdArb (
    .clk      (clk),
    .rst      (rst),
    .en       (rdCanLoad),
    .eligible (rdEligible),
    .grant    (rdGrant),
    .grantIdx (rdGrantIdx)
  );

  hld_rr_arbiter #(.N(WR_PORTS)) u_wrArb (
    .clk      (clk),
    .rst      (rst),
    .en       (wrCanLoad),
    .eligible (wrEligible),
    .grant    (wrGrant),
    .grantIdx (wrGrantIdx)
  );

  assign rd_req_in_ready = rdGrant;
  assign wr_req_in_ready = wrGrant;

  always_comb begin
    rdSel = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (rdGrant[p]) rdSel = rd_req_in_data[p*RD_REQ_W +: RD_REQ_W];
    end
    rdTagged = RD_REQ_W'(setTagPid(MAX_BUS_W'(rdSel), RD_REQ_W - 1, PID_W, 16'(rdGrantIdx)));
    wrSel = '0;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wrGrant[p]) wrSel = wr_req_in_data[p*WR_REQ_W +: WR_REQ_W];
    end
    wrTagged = WR_REQ_W'(setTagPid(MAX_BUS_W'(wrSel), WR_REQ_TAG_MSB, PID_W, 16'(wrGrantIdx)));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdOutValid_q <= 1'b0;
      rdOutData_q  <= '0;
      wrOutValid_q <= 1'b0;
      wrOutData_q  <= '0;
    end else begin
      if (|rdGrant) begin
        rdOutValid_q <= 1'b1;
        rdOutData_q  <= rdTagged;
      end else if (rd_req_out_ready) begin
        rdOutValid_q <= 1'b0;
      end
      if (|wrGrant) begin
        wrOutValid_q <= 1'b1;
        wrOutData_q  <= wrTagged;
      end else if (wr_req_out_ready) begin
        wrOutValid_q <= 1'b0;
      end
    end
  end

  assign rd_req_out_valid = rdOutValid_q;
  assign rd_req_out_data  = rdOutData_q;
  assign wr_req_out_valid = wrOutValid_q;
  assign wr_req_out_data  = wrOutData_q;

  // Responses with an out-of-range port id are swallowed (ready held high) and flagged.
  always_comb begin
    rdRespPid         = rd_resp_in_data[RD_RESP_W-1 -: PID_W];
    rdRespPidOk       = 1'b0;
    rd_resp_out_valid = '0;
    rd_resp_in_ready  = 1'b1;
    for (int p = 0; p < RD_PORTS; p++) begin
      if (rdRespPid == PID_W'(p)) begin
        rdRespPidOk          = 1'b1;
        rd_resp_out_valid[p] = rd_resp_in_valid;
        rd_resp_in_ready     = rd_resp_out_ready[p];
      end
    end
    rd_resp_out_data = RD_RESP_W'(setTagPid(MAX_BUS_W'(rd_resp_in_data), RD_RESP_W - 1, PID_W, 16'd0));

    wrRespPid         = wr_resp_in_data[TAG_W-1 -: PID_W];
    wrRespPidOk       = 1'b0;
    wr_resp_out_valid = '0;
    wr_resp_in_ready  = 1'b1;
    for (int p = 0; p < WR_PORTS; p++) begin
      if (wrRespPid == PID_W'(p)) begin
        wrRespPidOk          = 1'b1;
        wr_resp_out_valid[p] = wr_resp_in_valid;
        wr_resp_in_ready     = wr_resp_out_ready[p];
      end
    end
    wr_resp_out_data = WR_RESP_W'(setTagPid(MAX_BUS_W'(wr_resp_in_data), TAG_W - 1, PID_W, 16'd0));
  end

  assign rdDec       = rd_resp_out_valid & rd_resp_out_ready;
  assign wrDec       = wr_resp_out_valid & wr_resp_out_ready;
  assign rdUnderflow = |(rdDec & ~rdGrant & rdZero);
  assign wrUnderflow = |(wrDec & ~wrGrant & wrZero);
  assign badPid      = (rd_resp_in_valid && !rdRespPidOk) || (wr_resp_in_valid && !wrRespPidOk);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int p = 0; p < RD_PORTS; p++) rdCnt_q[p] <= '0;
      for (int p = 0; p < WR_PORTS; p++) wrCnt_q[p] <= '0;
    end else begin
      for (int p = 0; p < RD_PORTS; p++) begin
        if (rdGrant[p] && !rdDec[p]) rdCnt_q[p] <= rdCnt_q[p] + 1'b1;
        else if (rdDec[p] && !rdGrant[p] && !rdZero[p]) rdCnt_q[p] <= rdCnt_q[p] - 1'b1;
      end
      for (int p = 0; p < WR_PORTS; p++) begin
        if (wrGrant[p] && !wrDec[p]) wrCnt_q[p] <= wrCnt_q[p] + 1'b1;
        else if (wrDec[p] && !wrGrant[p] && !wrZero[p]) wrCnt_q[p] <= wrCnt_q[p] - 1'b1;
      end
    end
  end

  assign quiet = (&rdZero) && (&wrZero) && !rdOutValid_q && !wrOutValid_q &&
                 !(|rd_req_in_valid) && !(|wr_req_in_valid) &&
                 !rd_resp_in_valid && !wr_resp_in_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idleCnt_q <= '0;
      err_q     <= '0;
    end else begin
      if (!quiet) idleCnt_q <= '0;
      else if (idleCnt_q != IDLE_W'(IDLE_CYCLES)) idleCnt_q <= idleCnt_q + 1'b1;
      err_q <= err_q | {rdUnderflow || wrUnderflow, badPid};
    end
  end

  assign idle = (idleCnt_q == IDLE_W'(IDLE_CYCLES));
  assign err  = err_q;

endmodule

// File: tb/tb_hld_mem_channel_arbiter.sv
// Directed bench for hld_mem_channel_arbiter; a second 4-read-port instance covers
// the out-of-range write response id.
module tb_hld_mem_channel_arbiter;

  localparam int RQ = 80;
  localparam int RS = 528;
  localparam int WQ = 606;
  localparam int WS = 17;

  localparam logic [RQ-1:0] RD0   = {16'h8012, 64'h0000_0000_AAAA_0001};
  localparam logic [RQ-1:0] RD0_T = {16'h0012, 64'h0000_0000_AAAA_0001};
  localparam logic [RQ-1:0] RD1   = {16'h0034, 64'h0000_0000_BBBB_0002};
  localparam logic [RQ-1:0] RD1_T = {16'h8034, 64'h0000_0000_BBBB_0002};
  localparam logic [WQ-1:0] WR0   = {14'h0, 16'hFFFF, 576'h1234};
  localparam logic [WQ-1:0] WR0_T = {14'h0, 16'h7FFF, 576'h1234};

  logic clk, rst;
  int   assertCount, failCount;

  logic [1:0]    rd_req_in_valid, rd_req_in_ready, rd_resp_out_valid, rd_resp_out_ready;
  logic [2*RQ-1:0] rd_req_in_data;
  logic          rd_req_out_valid, rd_req_out_ready, rd_resp_in_valid, rd_resp_in_ready;
  logic [RQ-1:0] rd_req_out_data;
  logic [RS-1:0] rd_resp_in_data, rd_resp_out_data;
  logic [1:0]    wr_req_in_valid, wr_req_in_ready, wr_resp_out_valid, wr_resp_out_ready;
  logic [2*WQ-1:0] wr_req_in_data;
  logic          wr_req_out_valid, wr_req_out_ready, wr_resp_in_valid, wr_resp_in_ready;
  logic [WQ-1:0] wr_req_out_data;
  logic [WS-1:0] wr_resp_in_data, wr_resp_out_data;
  logic          idle;
  logic [1:0]    err;

  logic [3:0]    d4RdReqInValid, d4RdReqInReady, d4RdRespOutValid, d4RdRespOutReady;
  logic [4*RQ-1:0] d4RdReqInData;
  logic          d4RdReqOutValid, d4RdReqOutReady, d4RdRespInValid, d4RdRespInReady;
  logic [RQ-1:0] d4RdReqOutData;
  logic [RS-1:0] d4RdRespInData, d4RdRespOutData;
  logic [1:0]    d4WrReqInValid, d4WrReqInReady, d4WrRespOutValid, d4WrRespOutReady;
  logic [2*WQ-1:0] d4WrReqInData;
  logic          d4WrReqOutValid, d4WrReqOutReady, d4WrRespInValid, d4WrRespInReady;
  logic [WQ-1:0] d4WrReqOutData;
  logic [WS-1:0] d4WrRespInData, d4WrRespOutData;
  logic          d4Idle;
  logic [1:0]    d4Err;

  hld_mem_channel_arbiter dut (
    .clk(clk), .rst(rst),
    .rd_req_in_valid(rd_req_in_valid), .rd_req_in_data(rd_req_in_data), .rd_req_in_ready(rd_req_in_ready),
    .rd_req_out_valid(rd_req_out_valid), .rd_req_out_ready(rd_req_out_ready), .rd_req_out_data(rd_req_out_data),
    .rd_resp_in_valid(rd_resp_in_valid), .rd_resp_in_ready(rd_resp_in_ready), .rd_resp_in_data(rd_resp_in_data),
    .rd_resp_out_valid(rd_resp_out_valid), .rd_resp_out_ready(rd_resp_out_ready), .rd_resp_out_data(rd_resp_out_data),
    .wr_req_in_valid(wr_req_in_valid), .wr_req_in_ready(wr_req_in_ready), .wr_req_in_data(wr_req_in_data),
    .wr_req_out_valid(wr_req_out_valid), .wr_req_out_ready(wr_req_out_ready), .wr_req_out_data(wr_req_out_data),
    .wr_resp_in_valid(wr_resp_in_valid), .wr_resp_in_ready(wr_resp_in_ready), .wr_resp_in_data(wr_resp_in_data),
    .wr_resp_out_valid(wr_resp_out_valid), .wr_resp_out_ready(wr_resp_out_ready), .wr_resp_out_data(wr_resp_out_data),
    .idle(idle), .err(err)
  );

  hld_mem_channel_arbiter #(.RD_PORTS(4), .WR_PORTS(2)) dut4 (
    .clk(clk), .rst(rst),
    .rd_req_in_valid(d4RdReqInValid), .rd_req_in_data(d4RdReqInData), .rd_req_in_ready(d4RdReqInReady),
    .rd_req_out_valid(d4RdReqOutValid), .rd_req_out_ready(d4RdReqOutReady), .rd_req_out_data(d4RdReqOutData),
    .rd_resp_in_valid(d4RdRespInValid), .rd_resp_in_ready(d4RdRespInReady), .rd_resp_in_data(d4RdRespInData),
    .rd_resp_out_valid(d4RdRespOutValid), .rd_resp_out_ready(d4RdRespOutReady), .rd_resp_out_data(d4RdRespOutData),
    .wr_req_in_valid(d4WrReqInValid), .wr_req_in_ready(d4WrReqInReady), .wr_req_in_data(d4WrReqInData),
    .wr_req_out_valid(d4WrReqOutValid), .wr_req_out_ready(d4WrReqOutReady), .wr_req_out_data(d4WrReqOutData),
    .wr_resp_in_valid(d4WrRespInValid), .wr_resp_in_ready(d4WrRespInReady), .wr_resp_in_data(d4WrRespInData),
    .wr_resp_out_valid(d4WrRespOutValid), .wr_resp_out_ready(d4WrRespOutReady), .wr_resp_out_data(d4WrRespOutData),
    .idle(d4Idle), .err(d4Err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    rd_req_in_valid = '0; rd_req_in_data = '0; rd_req_out_ready = 1'b0;
    rd_resp_in_valid = 1'b0; rd_resp_in_data = '0; rd_resp_out_ready = '0;
    wr_req_in_valid = '0; wr_req_in_data = '0; wr_req_out_ready = 1'b0;
    wr_resp_in_valid = 1'b0; wr_resp_in_data = '0; wr_resp_out_ready = '0;
    d4RdReqInValid = '0; d4RdReqInData = '0; d4RdReqOutReady = 1'b0;
    d4RdRespInValid = 1'b0; d4RdRespInData = '0; d4RdRespOutReady = '0;
    d4WrReqInValid = '0; d4WrReqInData = '0; d4WrReqOutReady = 1'b0;
    d4WrRespInValid = 1'b0; d4WrRespInData = '0; d4WrRespOutReady = '0;
  endtask

  // Leaves the bench on a falling edge with reset just released.
  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    rd_req_in_data = {RD1, RD0};
    rd_req_in_valid = 2'b01;
    @(negedge clk);
    #1;
    assertCount++;
    if (rd_req_out_valid !== 1'b1) begin
      failCount++; $display("[TB] FAIL reset_preload: got %b expected 1", rd_req_out_valid);
    end
    rst = 1'b0;
    #1;
    assertCount++;
    if (rd_req_out_valid !== 1'b0 || wr_req_out_valid !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_valid: got rd=%b wr=%b expected 0 0", rd_req_out_valid, wr_req_out_valid);
    end
    assertCount++;
    if (rd_req_out_data !== '0) begin
      failCount++; $display("[TB] FAIL reset_data: got %h expected 0", rd_req_out_data);
    end
    assertCount++;
    if (idle !== 1'b0 || err !== 2'b00) begin
      failCount++; $display("[TB] FAIL reset_idle_err: got idle=%b err=%b expected 0 00", idle, err);
    end
    clear_inputs();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    assertCount++;
    if (rd_req_in_ready !== 2'b00 || rd_req_out_valid !== 1'b0) begin
      failCount++; $display("[TB] FAIL reset_release: got ready=%b valid=%b expected 00 0", rd_req_in_ready, rd_req_out_valid);
    end
  endtask

  task automatic test_rr_grant();
    logic [1:0]    expReady;
    logic [RQ-1:0] expData;
    do_reset();
    rd_req_out_ready = 1'b1;
    rd_req_in_data = {RD1, RD0};
    rd_req_in_valid = 2'b11;
    #1;
    assertCount++;
    if (rd_req_out_valid !== 1'b0) begin
      failCount++; $display("[TB] FAIL rr_latency: got %b expected 0", rd_req_out_valid);
    end
    expReady = 2'b10;
    for (int c = 0; c < 6; c++) begin
      assertCount++;
      if (rd_req_in_ready !== expReady) begin
        failCount++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", c, rd_req_in_ready, expReady);
      end
      expData = expReady[1] ? RD1_T : RD0_T;
      @(negedge clk);
      #1;
      assertCount++;
      if (rd_req_out_valid !== 1'b1 || rd_req_out_data !== expData) begin
        failCount++; $display("[TB] FAIL rr_data%0d: got %b/%h expected 1/%h", c, rd_req_out_valid, rd_req_out_data, expData);
      end
      expReady = ~expReady;
    end
    rd_req_in_valid = '0;
  endtask

  task automatic test_outstanding_limit();
    int accepted;
    do_reset();
    accepted = 0;
    rd_req_out_ready = 1'b1;
    rd_req_in_data = {RD1, RD0};
    rd_req_in_valid = 2'b01;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (rd_req_in_ready === 2'b01) accepted++;
      @(negedge clk);
    end
    #1;
    assertCount++;
    if (accepted !== 64) begin
      failCount++; $display("[TB] FAIL limit_accepts: got %0d expected 64", accepted);
    end
    assertCount++;
    if (rd_req_in_ready !== 2'b00) begin
      failCount++; $display("[TB] FAIL limit_block: got %b expected 00", rd_req_in_ready);
    end
    rd_req_in_valid = 2'b11;
    #1;
    assertCount++;
    if (rd_req_in_ready !== 2'b10) begin
      failCount++; $display("[TB] FAIL limit_other_port: got %b expected 10", rd_req_in_ready);
    end
    @(negedge clk);
    rd_resp_in_data = {16'h0007, 512'h55};
    rd_resp_in_valid = 1'b1;
    rd_resp_out_ready = 2'b01;
    #1;
    assertCount++;
    if (rd_resp_out_valid !== 2'b01 || rd_resp_in_ready !== 1'b1 || rd_req_in_ready !== 2'b10) begin
      failCount++; $display("[TB] FAIL limit_resp: got ov=%b ir=%b rq=%b expected 01 1 10", rd_resp_out_valid, rd_resp_in_ready, rd_req_in_ready);
    end
    @(negedge clk);
    rd_resp_in_valid = 1'b0;
    #1;
    assertCount++;
    if (rd_req_in_ready !== 2'b01) begin
      failCount++; $display("[TB] FAIL limit_regrant: got %b expected 01", rd_req_in_ready);
    end
    rd_req_in_valid = '0;
  endtask

  task automatic test_backpressure();
    int unstable;
    do_reset();
    unstable = 0;
    rd_req_in_data = {RD1, RD0};
    rd_req_in_valid = 2'b11;
    @(negedge clk);
    #1;
    assertCount++;
    if (rd_req_out_valid !== 1'b1 || rd_req_out_data !== RD1_T) begin
      failCount++; $display("[TB] FAIL bp_first: got %b/%h expected 1/%h", rd_req_out_valid, rd_req_out_data, RD1_T);
    end
    for (int i = 0; i < 5; i++) begin
      if (rd_req_in_ready !== 2'b00 || rd_req_out_data !== RD1_T || rd_req_out_valid !== 1'b1) unstable++;
      @(negedge clk);
      #1;
    end
    assertCount++;
    if (unstable !== 0) begin
      failCount++; $display("[TB] FAIL bp_hold: got %0d bad cycles expected 0", unstable);
    end
    rd_req_out_ready = 1'b1;
    #1;
    assertCount++;
    if (rd_req_in_ready !== 2'b01) begin
      failCount++; $display("[TB] FAIL bp_release: got %b expected 01", rd_req_in_ready);
    end
    @(negedge clk);
    #1;
    assertCount++;
    if (rd_req_out_data !== RD0_T) begin
      failCount++; $display("[TB] FAIL bp_drain0: got %h expected %h", rd_req_out_data, RD0_T);
    end
    @(negedge clk);
    #1;
    assertCount++;
    if (rd_req_out_data !== RD1_T) begin
      failCount++; $display("[TB] FAIL bp_drain1: got %h expected %h", rd_req_out_data, RD1_T);
    end
    rd_req_in_valid = '0;
    @(negedge clk);
    #1;
    assertCount++;
    if (rd_req_out_valid !== 1'b0) begin
      failCount++; $display("[TB] FAIL bp_empty: got %b expected 0", rd_req_out_valid);
    end
  endtask

  task automatic test_resp_routing();
    do_reset();
    rd_req_out_ready = 1'b1;
    rd_req_in_data = {RD1, RD0};
    rd_req_in_valid = 2'b10;
    @(negedge clk);
    rd_req_in_valid = '0;
    rd_resp_in_data = {16'h8005, 512'hC0FFEE};
    rd_resp_in_valid = 1'b1;
    rd_resp_out_ready = 2'b00;
    @(negedge clk);
    #1;
    assertCount++;
    if (rd_resp_out_valid !== 2'b10 || rd_resp_in_ready !== 1'b0) begin
      failCount++; $display("[TB] FAIL resp_stall: got ov=%b ir=%b expected 10 0", rd_resp_out_valid, rd_resp_in_ready);
    end
    rd_resp_out_ready = 2'b10;
    #1;
    assertCount++;
    if (rd_resp_in_ready !== 1'b1 || rd_resp_out_data !== {16'h0005, 512'hC0FFEE}) begin
      failCount++; $display("[TB] FAIL resp_deliver: got ir=%b data=%h", rd_resp_in_ready, rd_resp_out_data);
    end
    @(negedge clk);
    rd_resp_in_valid = 1'b0;
    #1;
    assertCount++;
    if (err !== 2'b00) begin
      failCount++; $display("[TB] FAIL resp_no_underflow: got %b expected 00", err);
    end
    rd_resp_in_valid = 1'b1;
    @(negedge clk);
    rd_resp_in_valid = 1'b0;
    #1;
    assertCount++;
    if (err !== 2'b10) begin
      failCount++; $display("[TB] FAIL resp_underflow: got %b expected 10", err);
    end
  endtask

  task automatic test_bad_pid();
    do_reset();
    d4WrRespInData = 17'h0C009;
    d4WrRespInValid = 1'b1;
    d4WrRespOutReady = 2'b11;
    #1;
    assertCount++;
    if (d4WrRespInReady !== 1'b1 || d4WrRespOutValid !== 2'b00) begin
      failCount++; $display("[TB] FAIL badpid_drop: got ir=%b ov=%b expected 1 00", d4WrRespInReady, d4WrRespOutValid);
    end
    @(negedge clk);
    d4WrRespInData = 17'h04009;
    d4WrRespOutReady = 2'b00;
    #1;
    assertCount++;
    if (d4Err !== 2'b01) begin
      failCount++; $display("[TB] FAIL badpid_err: got %b expected 01", d4Err);
    end
    assertCount++;
    if (d4WrRespOutValid !== 2'b10 || d4WrRespInReady !== 1'b0 || d4WrRespOutData !== 17'h00009) begin
      failCount++; $display("[TB] FAIL pid4_route: got ov=%b ir=%b data=%h expected 10 0 00009", d4WrRespOutValid, d4WrRespInReady, d4WrRespOutData);
    end
    d4WrRespInValid = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    assertCount++;
    if (d4Err !== 2'b01) begin
      failCount++; $display("[TB] FAIL badpid_sticky: got %b expected 01", d4Err);
    end
    do_reset();
    #1;
    assertCount++;
    if (d4Err !== 2'b00) begin
      failCount++; $display("[TB] FAIL badpid_clear: got %b expected 00", d4Err);
    end
  endtask

  task automatic test_idle();
    int early;
    do_reset();
    early = 0;
    wr_req_in_data = {{WQ{1'b0}}, WR0};
    wr_req_out_ready = 1'b1;
    wr_req_in_valid = 2'b01;
    #1;
    assertCount++;
    if (idle !== 1'b0) begin
      failCount++; $display("[TB] FAIL idle_busy: got %b expected 0", idle);
    end
    @(negedge clk);
    wr_req_in_valid = '0;
    #1;
    assertCount++;
    if (wr_req_out_valid !== 1'b1 || wr_req_out_data !== WR0_T) begin
      failCount++; $display("[TB] FAIL wr_tag: got %b tag=%h expected 1 7fff", wr_req_out_valid, wr_req_out_data[591:576]);
    end
    wr_resp_in_data = 17'h00003;
    wr_resp_in_valid = 1'b1;
    wr_resp_out_ready = 2'b01;
    #1;
    assertCount++;
    if (wr_resp_out_valid !== 2'b01 || wr_resp_in_ready !== 1'b1) begin
      failCount++; $display("[TB] FAIL wr_resp_route: got ov=%b ir=%b expected 01 1", wr_resp_out_valid, wr_resp_in_ready);
    end
    @(negedge clk);
    wr_resp_in_valid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      #1;
      if (k < 16 && idle !== 1'b0) early++;
    end
    assertCount++;
    if (early !== 0) begin
      failCount++; $display("[TB] FAIL idle_early: got %0d early cycles expected 0", early);
    end
    assertCount++;
    if (idle !== 1'b1) begin
      failCount++; $display("[TB] FAIL idle_at_16: got %b expected 1", idle);
    end
    wr_req_in_valid = 2'b01;
    #1;
    assertCount++;
    if (idle !== 1'b1) begin
      failCount++; $display("[TB] FAIL idle_before_edge: got %b expected 1", idle);
    end
    @(negedge clk);
    #1;
    assertCount++;
    if (idle !== 1'b0) begin
      failCount++; $display("[TB] FAIL idle_drop: got %b expected 0", idle);
    end
    wr_req_in_valid = '0;
  endtask

  initial begin
    assertCount = 0;
    failCount = 0;
    clear_inputs();
    rst = 1'b0;
    $display("[TB] starting hld_mem_channel_arbiter bench");
    test_reset();
    test_rr_grant();
    test_outstanding_limit();
    test_backpressure();
    test_resp_routing();
    test_bad_pid();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
